// File: rtl/index_store_pkg.sv
// Shared types for the FM-index backing store: table-select codes carried in
// the load-stream header, loader FSM encoding and table depths.
package index_store_pkg;

  localparam int C_DEPTH   = 4;
  localparam int OCC_DEPTH = 256;
  localparam int RD_DEPTH  = 256;

  typedef enum logic [1:0] {
    TBL_C   = 2'b00,
    TBL_OCC = 2'b01,
    TBL_RD  = 2'b10,
    TBL_END = 2'b11
  } tbl_e;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_CNT    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_e;

endpackage

// File: rtl/index_stream_parser.sv
// Load-stream parser: frames header/count/address/payload into table writes.
// Optional LOAD_CHECKSUM_EN adds a trailing XOR byte per frame (CHK state).
module index_stream_parser
  import index_store_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        loaded,
  output logic        err,
  output logic        wr_en,
  output tbl_e        wr_tbl,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data
);

  // Handshake: a byte moves only in a cycle where s_valid && s_ready; s_valid
  // may drop at any time and all partial-entry state simply holds.
  state_e      state_q, state_d;
  tbl_e        tbl_q, tbl_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] shadow_q, shadow_d;
  logic        ready_q, ready_d;
  logic        loaded_q, loaded_d;
  logic        err_q, err_d;
  logic        accept;
  logic        entry_done;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d;
`endif

  assign accept     = s_valid && ready_q;
  assign entry_done = (tbl_q == TBL_C) ||
                      (tbl_q == TBL_OCC && lane_q == 2'd3) ||
                      (tbl_q == TBL_RD  && lane_q == 2'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_HDR;
      tbl_q    <= TBL_C;
      cnt_q    <= 8'd0;
      addr_q   <= 8'd0;
      lane_q   <= 2'd0;
      shadow_q <= 24'd0;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      chk_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      tbl_q    <= tbl_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      lane_q   <= lane_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
`ifdef LOAD_CHECKSUM_EN
      chk_q    <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    tbl_d    = tbl_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    lane_d   = lane_q;
    shadow_d = shadow_q;
    loaded_d = loaded_q;
    err_d    = err_q;
`ifdef LOAD_CHECKSUM_EN
    chk_d    = chk_q;
`endif
    case (state_q)
      ST_HDR: if (accept) begin
        if (s_data[5:0] != 6'd0) begin
          err_d = 1'b1;
        end else if (tbl_e'(s_data[7:6]) == TBL_END) begin
          state_d = ST_COMMIT;
        end else begin
          tbl_d    = tbl_e'(s_data[7:6]);
          loaded_d = 1'b0;
          state_d  = ST_CNT;
        end
      end
      ST_CNT: if (accept) begin
        cnt_d   = s_data;
        state_d = ST_ADDR;
      end
      ST_ADDR: if (accept) begin
        addr_d  = (tbl_q == TBL_C) ? {6'd0, s_data[1:0]} : s_data;
        lane_d  = 2'd0;
`ifdef LOAD_CHECKSUM_EN
        chk_d   = 8'd0;
`endif
        state_d = ST_DATA;
      end
      ST_DATA: if (accept) begin
`ifdef LOAD_CHECKSUM_EN
        chk_d = chk_q ^ s_data;
`endif
        if (entry_done) begin
          lane_d = 2'd0;
          addr_d = (tbl_q == TBL_C) ? {6'd0, addr_q[1:0] + 2'd1} : addr_q + 8'd1;
          if (cnt_q == 8'd0) begin
`ifdef LOAD_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_HDR;
`endif
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else begin
          case (lane_q)
            2'd0:    shadow_d[7:0]   = s_data;
            2'd1:    shadow_d[15:8]  = s_data;
            default: shadow_d[23:16] = s_data;
          endcase
          lane_d = lane_q + 2'd1;
        end
      end
`ifdef LOAD_CHECKSUM_EN
      ST_CHK: if (accept) begin
        if (s_data != chk_q) err_d = 1'b1;
        state_d = ST_HDR;
      end
`endif
      ST_COMMIT: begin
        loaded_d = 1'b1;
        state_d  = ST_HDR;
      end
      default: state_d = ST_HDR;
    endcase
    ready_d = (state_d != ST_COMMIT);
  end

  always_comb begin
    s_ready = ready_q;
    loaded  = loaded_q;
    err     = err_q;
    wr_en   = (state_q == ST_DATA) && accept && entry_done;
    wr_tbl  = tbl_q;
    wr_addr = addr_q;
    case (tbl_q)
      TBL_C:   wr_data = {24'd0, s_data};
      TBL_OCC: wr_data = {s_data, shadow_q};
      TBL_RD:  wr_data = {22'd0, s_data[1:0], shadow_q[7:0]};
      default: wr_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/index_store.sv
// Writable FM-index tables (C, Occ, read/D) with zero-latency read ports that
// stay at 0 until a load is committed. Build option: LOAD_CHECKSUM_EN.
module index_store
  import index_store_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        loaded,
  output logic        err,
  input  logic        ce_rom_C,
  input  logic [1:0]  addr_rom_C,
  output logic [7:0]  data,
  input  logic        ce_rom_Occ,
  input  logic [7:0]  addr1_rom_Occ,
  input  logic [7:0]  addr2_rom_Occ,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  input  logic        ce_rom_read_and_D,
  input  logic [7:0]  addr_rom_read_and_D,
  output logic [7:0]  d_i,
  output logic [1:0]  read_i
);

  logic        wr_en;
  tbl_e        wr_tbl;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  logic [7:0]  c_mem   [C_DEPTH];
  logic [31:0] occ_mem [OCC_DEPTH];
  logic [9:0]  rd_mem  [RD_DEPTH];

  index_stream_parser u_parser (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .loaded  (loaded),
    .err     (err),
    .wr_en   (wr_en),
    .wr_tbl  (wr_tbl),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Table contents are deliberately not reset so a reset keeps loaded data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (wr_tbl)
        TBL_C:   c_mem[wr_addr[1:0]] <= wr_data[7:0];
        TBL_OCC: occ_mem[wr_addr]    <= wr_data;
        TBL_RD:  rd_mem[wr_addr]     <= wr_data[9:0];
        default: ;
      endcase
    end
  end

  logic [9:0] rd_word;
  assign rd_word = (loaded && ce_rom_read_and_D) ? rd_mem[addr_rom_read_and_D] : 10'd0;

  assign data   = (loaded && ce_rom_C)   ? c_mem[addr_rom_C]      : 8'd0;
  assign data_1 = (loaded && ce_rom_Occ) ? occ_mem[addr1_rom_Occ] : 32'd0;
  assign data_2 = (loaded && ce_rom_Occ) ? occ_mem[addr2_rom_Occ] : 32'd0;
  assign d_i    = rd_word[7:0];
  assign read_i = rd_word[9:8];

endmodule

// File: tb/tb_index_store.sv
// Bench for index_store: frame-level table model, random loads and reads,
// plus literal checks for reset, wrap, bad header, mid-frame reset, checksum.
module tb_index_store;
  import index_store_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready, loaded, err;
  logic        ce_rom_C, ce_rom_Occ, ce_rom_read_and_D;
  logic [1:0]  addr_rom_C;
  logic [7:0]  addr1_rom_Occ, addr2_rom_Occ, addr_rom_read_and_D;
  logic [7:0]  data, d_i;
  logic [31:0] data_1, data_2;
  logic [1:0]  read_i;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  logic [7:0]  m_c   [4];
  logic [31:0] m_occ [256];
  logic [9:0]  m_rd  [256];
  logic        m_loaded, m_err;
  logic [7:0]  pay_q[$];

  always #5 clk = ~clk;

  index_store dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .loaded(loaded), .err(err),
    .ce_rom_C(ce_rom_C), .addr_rom_C(addr_rom_C), .data(data),
    .ce_rom_Occ(ce_rom_Occ), .addr1_rom_Occ(addr1_rom_Occ), .addr2_rom_Occ(addr2_rom_Occ),
    .data_1(data_1), .data_2(data_2),
    .ce_rom_read_and_D(ce_rom_read_and_D), .addr_rom_read_and_D(addr_rom_read_and_D),
    .d_i(d_i), .read_i(read_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every read port, loaded and err against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_C", {24'd0, data},
          (m_loaded && ce_rom_C) ? {24'd0, m_c[addr_rom_C]} : 32'd0);
      chk("cmp_occ1", data_1, (m_loaded && ce_rom_Occ) ? m_occ[addr1_rom_Occ] : 32'd0);
      chk("cmp_occ2", data_2, (m_loaded && ce_rom_Occ) ? m_occ[addr2_rom_Occ] : 32'd0);
      chk("cmp_rd", {22'd0, read_i, d_i},
          (m_loaded && ce_rom_read_and_D) ? {22'd0, m_rd[addr_rom_read_and_D]} : 32'd0);
      chk("cmp_loaded", {31'd0, loaded}, {31'd0, m_loaded});
      chk("cmp_err", {31'd0, err}, {31'd0, m_err});
    end
  end

  task automatic put_byte(input logic [7:0] b, input bit gaps);
    bit done;
    done = 1'b0;
    if (gaps) begin
      @(negedge clk);
      s_valid = 1'b0;
      @(posedge clk);
    end
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge clk);
      s_data  = b;
      s_valid = 1'b1;
      if (s_ready) done = 1'b1;
      @(posedge clk);
    end
    #1 s_valid = 1'b0;
    if (!done) chk("put_byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [1:0] tbl, input int n, input logic [7:0] start,
                            input bit gaps, input bit bad_chk);
    int per;
    logic [7:0]  a, b, x;
    logic [31:0] w;
    per = (tbl == 2'd0) ? 1 : (tbl == 2'd1) ? 4 : 2;
    put_byte({tbl, 6'd0}, gaps);
    m_loaded = 1'b0;
    put_byte(n[7:0], gaps);
    put_byte(start, gaps);
    a = (tbl == 2'd0) ? {6'd0, start[1:0]} : start;
    x = 8'd0;
    for (int e = 0; e <= n; e++) begin
      w = 32'd0;
      for (int k = 0; k < per; k++) begin
        if (pay_q.size() > 0) b = pay_q.pop_front();
        else b = 8'($urandom);
        x = x ^ b;
        w[8*k +: 8] = b;
        put_byte(b, gaps);
      end
      case (tbl)
        2'd0:    m_c[a[1:0]] = w[7:0];
        2'd1:    m_occ[a]    = w;
        default: m_rd[a]     = w[9:0];
      endcase
      a = (tbl == 2'd0) ? {6'd0, a[1:0] + 2'd1} : a + 8'd1;
    end
`ifdef LOAD_CHECKSUM_EN
    put_byte(bad_chk ? ~x : x, gaps);
    if (bad_chk) m_err = 1'b1;
`endif
  endtask

  task automatic send_end();
    put_byte(8'hC0, 1'b0);
    @(negedge clk);
    chk("commit_loaded_low", {31'd0, loaded}, 32'd0);
    chk("commit_ready_low", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    chk("commit_loaded_high", {31'd0, loaded}, 32'd1);
    chk("commit_ready_high", {31'd0, s_ready}, 32'd1);
    m_loaded = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_loaded = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic idle_check(input int n);
    cmp_en = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      ce_rom_C            = ($urandom_range(0, 3) != 0);
      ce_rom_Occ          = ($urandom_range(0, 3) != 0);
      ce_rom_read_and_D   = ($urandom_range(0, 3) != 0);
      addr_rom_C          = 2'($urandom);
      addr1_rom_Occ       = 8'($urandom);
      addr2_rom_Occ       = ($urandom_range(0, 4) == 0) ? addr1_rom_Occ : 8'($urandom);
      addr_rom_read_and_D = 8'($urandom);
    end
    @(negedge clk);
    #1 cmp_en = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tbl;
    int n;
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'd0;
    ce_rom_C = 1'b1; ce_rom_Occ = 1'b1; ce_rom_read_and_D = 1'b1;
    addr_rom_C = 2'd0; addr1_rom_Occ = 8'd0; addr2_rom_Occ = 8'd0; addr_rom_read_and_D = 8'd0;
    m_loaded = 1'b0; m_err = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_loaded", {31'd0, loaded}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_data_1", data_1, 32'd0);
    chk("rst_data_2", data_2, 32'd0);
    chk("rst_rd", {22'd0, read_i, d_i}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("post_rst_loaded", {31'd0, loaded}, 32'd0);

    // Fill every table entry so all later random reads have known contents.
    send_frame(2'd0, 3, 8'd0, 1'b0, 1'b0);
    send_frame(2'd1, 255, 8'd0, 1'b0, 1'b0);
    send_frame(2'd2, 255, 8'd0, 1'b0, 1'b0);
    send_end();
    idle_check(40);

    pay_q = '{8'd0, 8'd1, 8'd5, 8'd9};
    send_frame(2'd0, 3, 8'h00, 1'b0, 1'b0);
    send_end();
    ce_rom_C = 1'b1; addr_rom_C = 2'd2;
    @(negedge clk);
    chk("c_lit_dut", {24'd0, data}, 32'd5);
    chk("c_lit_model", {24'd0, m_c[3]}, 32'd9);

    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame(2'd1, 1, 8'hFF, 1'b0, 1'b0);
    send_end();
    ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd255; addr2_rom_Occ = 8'd0;
    @(negedge clk);
    chk("occ_row255", data_1, 32'h44332211);
    chk("occ_row0_wrap", data_2, 32'h88776655);
    chk("occ_model_row0", m_occ[0], 32'h88776655);
    addr2_rom_Occ = 8'd255;
    @(negedge clk);
    chk("occ_same_addr", data_2, 32'h44332211);

    put_byte(8'h81, 1'b0);
    m_err = 1'b1;
    @(negedge clk);
    chk("badhdr_err", {31'd0, err}, 32'd1);
    chk("badhdr_loaded_kept", {31'd0, loaded}, 32'd1);
    chk("badhdr_state", 32'(dut.u_parser.state_q), 32'(ST_HDR));
    pay_q = '{8'h3C, 8'h02, 8'hA5, 8'h01};
    send_frame(2'd2, 1, 8'h20, 1'b0, 1'b0);
    send_end();
    ce_rom_read_and_D = 1'b1; addr_rom_read_and_D = 8'h21;
    @(negedge clk);
    chk("rd_lit", {22'd0, read_i, d_i}, 32'h1A5);
    idle_check(20);

    // Gapped RD load, reset in the middle of its second entry.
    put_byte(8'h80, 1'b1);
    m_loaded = 1'b0;
    put_byte(8'h01, 1'b1);
    put_byte(8'h40, 1'b1);
    put_byte(8'hAA, 1'b1);
    put_byte(8'h03, 1'b1);
    m_rd[8'h40] = 10'h3AA;
    put_byte(8'h55, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_state", 32'(dut.u_parser.state_q), 32'(ST_HDR));
    chk("midrst_loaded", {31'd0, loaded}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    m_loaded = 1'b0; m_err = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {31'd0, s_ready}, 32'd1);
    pay_q = '{8'h77, 8'h01, 8'h66, 8'h02};
    send_frame(2'd2, 1, 8'h40, 1'b1, 1'b0);
    send_end();
    addr_rom_read_and_D = 8'h41;
    @(negedge clk);
    chk("restart_rd", {22'd0, read_i, d_i}, 32'h266);
    idle_check(20);

`ifdef LOAD_CHECKSUM_EN
    do_reset();
    send_frame(2'd0, 1, 8'd1, 1'b0, 1'b1);
    @(negedge clk);
    chk("chk_bad_err", {31'd0, err}, 32'd1);
    do_reset();
    send_frame(2'd0, 1, 8'd1, 1'b0, 1'b0);
    @(negedge clk);
    chk("chk_good_err", {31'd0, err}, 32'd0);
    send_end();
    idle_check(10);
`endif

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 3)) begin
        tbl = 2'($urandom_range(0, 2));
        n = (tbl == 2'd1) ? $urandom_range(0, 40) : $urandom_range(0, 20);
        send_frame(tbl, n, 8'($urandom), bit'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0));
      end
      if ($urandom_range(0, 3) != 0) send_end();
      idle_check(30);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/index_store.md
# index_store

Writable backing store for the FM-index tables (C, Occ, read/D) and the responder for the read side of the data-fetch stage. It is loaded over a byte stream with a valid/ready handshake, commits on an explicit end header, and then answers the fetch stage's three ROM-style read ports combinationally. It replaces the fixed ROMs so that new references and reads can be loaded at run time.

## Interface
- No parameters; widths are fixed by the fetch-stage ports.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- s_data  in  8  load stream byte
- s_valid  in  1  s_data valid
- s_ready  out  1  store accepts a byte
- loaded  out  1  tables committed and readable
- err  out  1  sticky protocol/checksum error
- ce_rom_C  in  1  C read enable
- addr_rom_C  in  2  C index (0=A,1=C,2=G,3=T)
- data  out  8  C value
- ce_rom_Occ  in  1  Occ read enable, both ports
- addr1_rom_Occ, addr2_rom_Occ  in  8 each  Occ row addresses
- data_1, data_2  out  32 each  Occ rows, A in [7:0], C [15:8], G [23:16], T [31:24]
- ce_rom_read_and_D  in  1  read/D enable
- addr_rom_read_and_D  in  8  position
- d_i  out  8  D value
- read_i  out  2  read base

## Operation
- Storage: C 4x8, Occ 256x32, RD 256x10 ({read[1:0], D[7:0]}). Contents are not reset.
- A byte is accepted on s_valid && s_ready.
- Frame: header, count N (N+1 entries), start address, payload. Header [7:6]: 00 C, 01 Occ, 10 RD, 11 END; [5:0] must be 0.
- Payload: C takes 1 byte per entry. Occ takes 4 bytes, little-endian (byte0 → [7:0]), and writes on the 4th byte. RD takes 2 bytes: byte0 = D, byte1[1:0] = read, and writes on the 2nd byte.
- The write address starts at the start address and increments per entry, wrapping mod 4 for C and mod 256 for Occ/RD; the C start address uses bits [1:0].
- FSM: HDR → CNT → ADDR → DATA → HDR after the last entry. HDR on END header → COMMIT → HDR.
- A table header (00/01/10) in HDR clears loaded.
- A nonzero reserved field sets err; the header byte is dropped and the FSM stays in HDR.
- COMMIT sets loaded=1 and holds s_ready=0 for that cycle.
- Reads are combinational. With loaded && ce high the output shows the array at the address; otherwise the output is 0. The two Occ ports are independent, and equal addresses are legal.
- Reset mid-frame returns the FSM to HDR with loaded=0 and err=0. Partially written entries keep their data.

## Timing
- Reset values: s_ready=0, loaded=0, err=0. Read outputs are 0 because loaded=0.
- s_ready=1 from the first cycle after reset release, except in COMMIT.
- An array write takes effect at the clock edge that accepts the completing byte and is visible to a read the next cycle. Loaded gating means reads never observe loading in progress.
- loaded rises one cycle after the END header is accepted.
- The read path has zero latency (same cycle as address/ce), which the fetch stage requires.
- An s_valid gap mid-entry holds the lane counter and shadow bytes indefinitely.

## Configuration
- LOAD_CHECKSUM_EN defined: after each payload the FSM enters CHK and accepts one byte, which must equal the XOR of all payload bytes of that frame. On mismatch, err=1 and loaded is not affected. Then → HDR.
- Undefined: no CHK state, and DATA → HDR directly.

## Structure
- Package index_store_pkg holds the table-select codes (TBL_C, TBL_OCC, TBL_RD, TBL_END), the FSM state encoding, and the array depths.
- Sub-module index_stream_parser contains the FSM, counters, shadow bytes and checksum, and emits a write strobe, table, address and 32-bit word. The top level holds the arrays and the read muxing.

## Test plan
- Reset, then read with all ce=1 → all outputs 0, s_ready=1 one cycle after release, loaded=0.
- Load C 0x00,0x03,0x00,{0,1,5,9}, then END → loaded=1; addr_rom_C=2 → data=5.
- Load Occ 0x40,0x01,0xFF with bytes 11 22 33 44 55 66 77 88 → row 255=0x44332211 and row 0=0x88776655 (wrap). addr1=255, addr2=0 → both rows returned in the same cycle.
- Header 0x81 → err=1, FSM in HDR. A following valid RD frame still loads correctly.
- s_valid toggled every other cycle during a 2-entry RD load, with rst_n pulsed mid-entry → FSM back in HDR, loaded=0, err=0. A restarted frame writes correctly.
- With LOAD_CHECKSUM_EN, a C frame with a wrong checksum byte → err=1. The same frame with the correct XOR → err stays 0.
